// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Bundles the display-side signals of the seven-segment scanner.
//   master : time/keyboard-entry datapath (drives value, cursor, DP, mode)
//   slave  : seg7_scan_display (drives tube select, segments, frame pulse)
//   en            edit mode, enables cursor blink
//   active_digits number of scanned digits (0 -> 1, >DIGITS -> DIGITS)
//   digits        packed 4-bit codes, digit 0 = rightmost tube
//   cursor        index of the digit being edited
//   dp_mask       1 lights the DP of that digit
//   seg_en        active-low tube select
//   seg_out       active-low segments, bit7 = DP, bits6..0 = g..a
//   frame_tick    one-cycle pulse when the scan wraps to digit 0
`timescale 1ns/1ps
interface seg7_scan_display_if #(
  parameter int DIGITS = 8
);
  logic                  en;
  logic [3:0]            active_digits;
  logic [4*DIGITS-1:0]   digits;
  logic [2:0]            cursor;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     seg_en;
  logic [7:0]            seg_out;
  logic                  frame_tick;

  modport master (
    output en, active_digits, digits, cursor, dp_mask,
    input  seg_en, seg_out, frame_tick
  );

  modport slave (
    input  en, active_digits, digits, cursor, dp_mask,
    output seg_en, seg_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Time-multiplexed common-anode seven-segment driver. Scans up to DIGITS
//   tubes, one SCAN_DIV-cycle slot per digit whose last cycle is blanked to
//   suppress ghosting. In edit mode the cursor digit blinks with a
//   free-running half-period of BLINK_DIV cycles.
//   Ports: clk, rst (async, active high), bus (seg7_scan_display_if.slave).
//   Macro SEG7_HEX_EN: when defined, codes 10..15 show A b C d E F;
//   otherwise they blank segments g..a (DP and blink still apply).
`timescale 1ns/1ps

// Per-digit decoder: code + DP -> active-low segment byte.
module seg7_lane (
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [6:0] seg_lo;

  always_comb begin
    seg_lo = 7'h7F;
    case (code)
      4'h0: seg_lo = 7'h40;
      4'h1: seg_lo = 7'h79;
      4'h2: seg_lo = 7'h24;
      4'h3: seg_lo = 7'h30;
      4'h4: seg_lo = 7'h19;
      4'h5: seg_lo = 7'h12;
      4'h6: seg_lo = 7'h02;
      4'h7: seg_lo = 7'h78;
      4'h8: seg_lo = 7'h00;
      4'h9: seg_lo = 7'h18;
`ifdef SEG7_HEX_EN
      4'hA: seg_lo = 7'h08;
      4'hB: seg_lo = 7'h03;
      4'hC: seg_lo = 7'h46;
      4'hD: seg_lo = 7'h21;
      4'hE: seg_lo = 7'h06;
      4'hF: seg_lo = 7'h0E;
`endif
      default: seg_lo = 7'h7F;
    endcase
  end

  assign seg = {~dp, seg_lo};
endmodule

module seg7_scan_display #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_display_if.slave bus
);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]         DIG4      = 4'(DIGITS);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [3:0]         eff_active, idx4, idx_inc;
  logic               scan_tick, blink_wrap, cursor_hit;
  logic [DIGITS-1:0]  seg_en_q;
  logic [7:0]         seg_out_q;
  logic               frame_tick_q;
  logic [DIGITS-1:0][7:0] lane_seg;
  logic [7:0]         sel_seg;

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_lane
    seg7_lane u_lane (
      .code (bus.digits[4*g +: 4]),
      .dp   (bus.dp_mask[g]),
      .seg  (lane_seg[g])
    );
  end

  always_comb begin
    eff_active = bus.active_digits;
    if (bus.active_digits == 4'd0)     eff_active = 4'd1;
    else if (bus.active_digits > DIG4) eff_active = DIG4;
  end

  assign scan_tick  = (scan_cnt == SCAN_MAX);
  assign blink_wrap = (blink_cnt == BLINK_MAX);
  assign idx4       = 4'(idx);
  assign idx_inc    = idx4 + 4'd1;
  // ">=" rather than "==" so a mid-frame shrink of active_digits still
  // returns to digit 0 on the next slot boundary.
  assign idx_nxt    = (idx_inc >= eff_active) ? '0 : idx_inc[IDX_W-1:0];
  assign sel_seg    = lane_seg[idx];

  // A cursor outside the scanned range never blinks, even if idx is
  // briefly out of range after a shrink.
  assign cursor_hit = bus.en && blink_phase &&
                      ({1'b0, bus.cursor} < eff_active) &&
                      ({1'b0, bus.cursor} == idx4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt     <= '0;
      idx          <= '0;
      seg_en_q     <= '1;
      seg_out_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else if (scan_tick) begin
      scan_cnt     <= '0;
      idx          <= idx_nxt;
      seg_en_q     <= '1;
      seg_out_q    <= 8'hFF;
      frame_tick_q <= (idx_nxt == '0);
    end else begin
      scan_cnt     <= scan_cnt + SCAN_W'(1);
      seg_en_q     <= ~(DIGITS'(1) << idx);
      seg_out_q    <= cursor_hit ? 8'hFF : sel_seg;
      frame_tick_q <= 1'b0;
    end
  end

  // Blink timebase is free-running, independent of the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  assign bus.seg_en     = seg_en_q;
  assign bus.seg_out    = seg_out_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display
//   Directed bench for seg7_scan_display with DIGITS=4, SCAN_DIV=4,
//   BLINK_DIV=16. Cycle n is the n-th rising edge after reset release;
//   outputs are sampled 1 ns after that edge. In a 4-digit frame digit k is
//   lit on cycles 16m+4k+1..16m+4k+3 and cycle 16m+4k+4 is blank; the blink
//   phase seen on cycle 16m+j (j=1..16) equals m mod 2.
`timescale 1ns/1ps
module tb_seg7_scan_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   cnt, bad;

  always #5 clk = ~clk;

  seg7_scan_display_if #(.DIGITS(4)) bus ();

  seg7_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %02h expected %02h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] en_exp, input logic [7:0] seg_exp);
    check({tag, ".seg_en"}, {4'h0, bus.seg_en}, {4'h0, en_exp});
    check({tag, ".seg_out"}, bus.seg_out, seg_exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    bus.en            = 1'b0;
    bus.active_digits = 4'd4;
    bus.digits        = 16'h4321;
    bus.cursor        = 3'd0;
    bus.dp_mask       = 4'b0000;

    // Reset state
    @(posedge clk);
    #1;
    chk_out("reset", 4'b1111, 8'hFF);
    check("reset.frame_tick", {7'h0, bus.frame_tick}, 8'h00);
    do_reset();

    // Reset release scan order
    run_to(1);  chk_out("c1.d0", 4'b1110, 8'hF9);
    run_to(3);  chk_out("c3.d0", 4'b1110, 8'hF9);
    run_to(4);  chk_out("c4.blank", 4'b1111, 8'hFF);
    check("c4.frame_tick", {7'h0, bus.frame_tick}, 8'h00);
    run_to(5);  chk_out("c5.d1", 4'b1101, 8'hA4);
    run_to(9);  chk_out("c9.d2", 4'b1011, 8'hB0);
    run_to(13); chk_out("c13.d3", 4'b0111, 8'h99);
    run_to(15); check("c15.frame_tick", {7'h0, bus.frame_tick}, 8'h00);
    run_to(16); check("c16.frame_tick", {7'h0, bus.frame_tick}, 8'h01);
    chk_out("c16.blank", 4'b1111, 8'hFF);
    cnt = 0;
    while (cyc < 48) begin tick(); if (bus.frame_tick) cnt++; end
    check("ft_count_4dig", 8'(cnt), 8'd2);

    // active_digits=0 -> one digit, frame every 4 cycles
    bus.active_digits = 4'd0;
    cnt = 0; bad = 0;
    while (cyc < 68) begin
      tick();
      if (bus.frame_tick) cnt++;
      if (bus.seg_en != 4'b1110 && bus.seg_en != 4'b1111) bad++;
    end
    check("ft_count_1dig", 8'(cnt), 8'd5);
    check("only_d0_lit", 8'(bad), 8'd0);

    // active_digits=9 clamps to 4
    bus.active_digits = 4'd9;
    run_to(81); chk_out("clamp9.d3", 4'b0111, 8'h99);
    run_to(84); check("clamp9.frame_tick", {7'h0, bus.frame_tick}, 8'h01);

    // Shrink 4 -> 2 while on digit 3
    run_to(97); chk_out("shrink.d3", 4'b0111, 8'h99);
    bus.active_digits = 4'd2;
    run_to(100); check("shrink.frame_tick", {7'h0, bus.frame_tick}, 8'h01);
    run_to(101); chk_out("shrink.d0", 4'b1110, 8'hF9);
    run_to(105); chk_out("shrink.d1", 4'b1101, 8'hA4);
    run_to(108); check("shrink.wrap2", {7'h0, bus.frame_tick}, 8'h01);

    // Blink: fresh reset aligns blink phase with frames
    bus.active_digits = 4'd4;
    bus.digits        = 16'h0000;
    bus.en            = 1'b1;
    bus.cursor        = 3'd2;
    do_reset();
    run_to(9);  chk_out("blink.f0.d2", 4'b1011, 8'hC0);
    run_to(17); chk_out("blink.f1.d0", 4'b1110, 8'hC0);
    run_to(21); chk_out("blink.f1.d1", 4'b1101, 8'hC0);
    run_to(25); chk_out("blink.f1.d2", 4'b1011, 8'hFF);
    run_to(29); chk_out("blink.f1.d3", 4'b0111, 8'hC0);
    run_to(41); chk_out("blink.f2.d2", 4'b1011, 8'hC0);
    run_to(57); chk_out("blink.f3.d2", 4'b1011, 8'hFF);
    run_to(64); bus.cursor = 3'd5;
    run_to(89); chk_out("cursor5.f5.d2", 4'b1011, 8'hC0);

    // DP on digit 2
    bus.dp_mask = 4'b0100;
    run_to(97);  chk_out("dp.d0", 4'b1110, 8'hC0);
    run_to(105); chk_out("dp.d2", 4'b1011, 8'h40);
    run_to(109); chk_out("dp.d3", 4'b0111, 8'hC0);
    run_to(110); bus.cursor = 3'd2;
    run_to(121); chk_out("dp.blink.d2", 4'b1011, 8'hFF);
    run_to(122); chk_out("dp.blink.d2b", 4'b1011, 8'hFF);

    // Hex code on digit 1
    bus.cursor  = 3'd5;
    bus.dp_mask = 4'b0000;
    bus.digits  = 16'h00A0;
    run_to(133);
`ifdef SEG7_HEX_EN
    chk_out("hexA", 4'b1101, 8'h88);
`else
    chk_out("hexA", 4'b1101, 8'hFF);
`endif
    bus.dp_mask = 4'b0010;
    run_to(134);
`ifdef SEG7_HEX_EN
    chk_out("hexA.dp", 4'b1101, 8'h08);
`else
    chk_out("hexA.dp", 4'b1101, 8'h7F);
`endif

    // Async reset mid-slot on digit 2
    run_to(137); chk_out("pre_rst.d2", 4'b1011, 8'hFF ^ 8'hFF ^ 8'hC0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 4'b1111, 8'hFF);
    check("async_rst.frame_tick", {7'h0, bus.frame_tick}, 8'h00);
    #1 rst = 1'b0;
    cyc = 0;
    run_to(1); chk_out("rel.c1", 4'b1110, 8'hC0);
    run_to(3); chk_out("rel.c3", 4'b1110, 8'hC0);
    run_to(4); chk_out("rel.c4", 4'b1111, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised time-multiplexed seven-segment driver for the clock/alarm display path. It scans up to `DIGITS` common-anode tubes from a packed 4-bit-per-digit value bus, with a runtime-selectable number of active digits and per-digit decimal points. A blinking edit cursor and a one-cycle inter-digit blanking gap suppress ghosting. It sits between the time/keyboard-entry datapath and the board's `seg_en`/`seg_out` pins.

## Interface
- `DIGITS`, 8: number of physical tubes, 1..8.
- `SCAN_DIV`, 50_000: clk cycles per digit slot, including the blank cycle; ≥2.
- `BLINK_DIV`, 25_000_000: clk cycles per blink half-period.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: edit mode; enables cursor blinking.
- `active_digits` in 4: number of digits scanned; 0 is treated as 1, values above `DIGITS` are treated as `DIGITS`.
- `digits` in 4*DIGITS: digit i is `digits[4i+3:4i]`; i=0 is the rightmost tube.
- `cursor` in 3: index of the digit being edited.
- `dp_mask` in DIGITS: 1 lights the DP of that digit.
- `seg_en` out DIGITS: active-low tube select.
- `seg_out` out 8: active-low segments, bit7=DP, bits6..0 = g..a.
- `frame_tick` out 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- `scan_cnt` counts 0..SCAN_DIV-1 and wraps. `scan_tick` = (scan_cnt == SCAN_DIV-1).
- `idx` is the current digit. On the scan_tick edge, `idx` becomes 0 if idx+1 ≥ eff_active, otherwise idx+1.
  - eff_active is `active_digits` after clamping.
  - If `active_digits` shrinks below idx+1 mid-frame, the next tick goes to 0.
- Scan_tick edge (blanking cycle):
  - `seg_en` is all ones and `seg_out` = 8'hFF.
  - `frame_tick` is 1 iff the new idx is 0; otherwise `frame_tick` is 0.
- Every other edge:
  - `seg_en` is all ones except bit idx, which is 0.
  - `seg_out` = decode(digits[idx]), with bit7 = ~dp_mask[idx].
  - `frame_tick` is 0.
  - `digits` and `dp_mask` are sampled live each cycle; there is no latching.
- Blink:
  - `blink_cnt` counts 0..BLINK_DIV-1 and wraps. `blink_phase` toggles on wrap.
  - When en=1, idx==cursor and blink_phase=1, `seg_out` = 8'hFF. `seg_en` is unchanged.
  - Blink overrides DP.
  - A `cursor` ≥ eff_active blinks nothing.
- Decode, 0..9: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→98 (bits6..0; bit7 set by the DP rule).
- Decode, 10..15: see Configuration.
- Reset values: scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0, seg_en all ones, seg_out=8'hFF, frame_tick=0.

## Timing
- All outputs are registered. Output latency is 1 clk from `digits`/`dp_mask`/`cursor`/`en` to `seg_out`.
- Each digit is lit SCAN_DIV-1 cycles, then blanked 1 cycle. The frame period is eff_active×SCAN_DIV cycles.
- With `active_digits` constant, `frame_tick` fires every eff_active×SCAN_DIV cycles. The first pulse is SCAN_DIV×eff_active cycles after reset release.
- Blink period is 2×BLINK_DIV cycles and is free-running, independent of the scan.
- `rst` asserted at any time forces the reset values immediately. The scan restarts at digit 0 with scan_cnt=0 on the first edge after release.
- A `cursor` change takes effect on the next non-blank cycle of the matching digit.

## Configuration
- `SEG7_HEX_EN` defined: codes 10..15 decode as A→88, b→83, C→C6, d→A1, E→86, F→8E.
- `SEG7_HEX_EN` undefined: codes 10..15 blank segments g..a (7'h7F). DP still follows `dp_mask`, and blink still applies.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, BLINK_DIV=16.

- **Reset release:** digits=16'h4321, active_digits=4, en=0.
  - Cycles 1..3: seg_en=1110, seg_out=F9.
  - Cycle 4: blank (1111/FF).
  - Then seg_en=1101, seg_out=A4.
  - `frame_tick` pulses once every 16 cycles.
- **Active-digit clamp:**
  - active_digits=0: only digit 0 is lit; frame_tick every 4 cycles.
  - active_digits=9: 4 digits scanned.
  - Drop active_digits from 4 to 2 while idx=3: next tick goes to idx=0.
- **Blink:** en=1, cursor=2, digits=16'h0000.
  - Digit 2 shows FF during 16-cycle windows with blink_phase=1 and C0 otherwise.
  - Digits 0, 1 and 3 always show C0.
  - cursor=5 (≥ eff_active): no digit blinks.
- **DP:** dp_mask=4'b0100, digits=16'h0000.
  - Digit 2 shows 40, the others C0.
  - During a blink-off phase with cursor=2, digit 2 shows FF.
- **Hex digit:** digits nibble 4'hA on digit 1.
  - With SEG7_HEX_EN: seg_out=88.
  - Without SEG7_HEX_EN: FF; with dp_mask[1]=1: 7F.
- **Async reset mid-scan:** assert rst between clock edges at idx=2.
  - Outputs go to 1111/FF before the next edge.
  - After release the scan resumes from idx=0 with a full 3-cycle slot.
